// File: rtl/nn_pkg.sv
// Shared definitions for the classifier datapath.
//   N_CLASSES / DATA_W / IDX_W : vector shape and element / index widths
//   ONE                        : 1.0 in unsigned Q1.15
//   CONF_THRESH / MARGIN_MIN   : confidence thresholds (0.5 and ~0.1)
//   class_idx_t, prob_t        : index and probability types
//   state_t                    : classifier FSM states
package nn_pkg;

    localparam int N_CLASSES = 10;
    localparam int DATA_W    = 16;
    localparam int IDX_W     = 4;

    localparam logic [DATA_W-1:0] ONE         = 16'h8000;
    localparam logic [DATA_W-1:0] CONF_THRESH = ONE >> 1;
    localparam logic [DATA_W-1:0] MARGIN_MIN  = 16'h0CCD;

    typedef logic [IDX_W-1:0]  class_idx_t;
    typedef logic [DATA_W-1:0] prob_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SCAN,
        ST_RESULT
    } state_t;

endpackage

// File: rtl/top2_update.sv
// Combinational top-2 tracker step.
//   elem        : candidate probability
//   cnt         : index of the candidate
//   best/second : current top-1 / top-2 values
//   idx         : current top-1 index
//   best_next / second_next / idx_next : updated tracker state
// Only a strictly larger element displaces the leader, so ties keep the
// lowest index and an equal value lands in second (margin 0).
module top2_update
    import nn_pkg::*;
(
    input  logic [DATA_W-1:0] elem,
    input  logic [IDX_W-1:0]  cnt,
    input  logic [DATA_W-1:0] best,
    input  logic [DATA_W-1:0] second,
    input  logic [IDX_W-1:0]  idx,
    output logic [DATA_W-1:0] best_next,
    output logic [DATA_W-1:0] second_next,
    output logic [IDX_W-1:0]  idx_next
);

    always_comb begin
        best_next   = best;
        second_next = second;
        idx_next    = idx;
        if (elem > best) begin
            second_next = best;
            best_next   = elem;
            idx_next    = cnt;
        end else if (elem > second) begin
            second_next = elem;
        end
    end

endmodule

// File: rtl/softmax_argmax_classifier.sv
// Top-1 / top-2 classifier for one softmax probability vector.
//   clk, rst (async active-low)
//   prob_in       : N_CLASSES packed Q1.15 values, class i at [i*DATA_W +: DATA_W]
//   in_valid      : one-cycle vector strobe
//   out_ready     : consumer accepts the result
//   clear_overrun : clears the sticky overrun flag
//   out_valid, class_idx, top_prob, margin, confident : result, held until accepted
//   busy          : scanning or holding a result
//   overrun       : sticky, a vector arrived while it could not be taken
// The vector is captured in IDLE, scanned one class per cycle, and the result
// registers are loaded on the first RESULT cycle, giving a 10-cycle latency.
module softmax_argmax_classifier
    import nn_pkg::*;
(
    input  logic                          clk,
    input  logic                          rst,
    input  logic [N_CLASSES*DATA_W-1:0]   prob_in,
    input  logic                          in_valid,
    input  logic                          out_ready,
    input  logic                          clear_overrun,
    output logic                          out_valid,
    output logic [IDX_W-1:0]              class_idx,
    output logic [DATA_W-1:0]             top_prob,
    output logic [DATA_W-1:0]             margin,
    output logic                          confident,
    output logic                          busy,
    output logic                          overrun
);

    prob_t      elem_in [N_CLASSES];
    prob_t      vec_reg [N_CLASSES];
    state_t     state;
    class_idx_t cnt;
    class_idx_t idx_reg;
    prob_t      best_reg;
    prob_t      second_reg;

    prob_t      best_next;
    prob_t      second_next;
    class_idx_t idx_next;
    prob_t      margin_calc;

    logic transfer;
    logic capture;
    logic drop;

    generate
        for (genvar gi = 0; gi < N_CLASSES; gi++) begin : g_unpack
            assign elem_in[gi] = prob_in[gi*DATA_W +: DATA_W];
        end
    endgenerate

    // A vector can be taken when idle, or in the very cycle the held result leaves.
    assign transfer    = (state == ST_RESULT) && out_valid && out_ready;
    assign capture     = in_valid && ((state == ST_IDLE) || transfer);
    assign drop        = in_valid && !capture;
    assign busy        = (state != ST_IDLE);
    assign margin_calc = best_reg - second_reg;

    top2_update u_top2 (
        .elem        (vec_reg[cnt]),
        .cnt         (cnt),
        .best        (best_reg),
        .second      (second_reg),
        .idx         (idx_reg),
        .best_next   (best_next),
        .second_next (second_next),
        .idx_next    (idx_next)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < N_CLASSES; i++) begin
                vec_reg[i] <= '0;
            end
        end else if (capture) begin
            for (int i = 0; i < N_CLASSES; i++) begin
                vec_reg[i] <= elem_in[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            best_reg   <= '0;
            second_reg <= '0;
            idx_reg    <= '0;
            out_valid  <= 1'b0;
            class_idx  <= '0;
            top_prob   <= '0;
            margin     <= '0;
            confident  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: ;
                ST_SCAN: begin
                    best_reg   <= best_next;
                    second_reg <= second_next;
                    idx_reg    <= idx_next;
                    if (cnt == class_idx_t'(N_CLASSES - 1)) begin
                        state <= ST_RESULT;
                    end else begin
                        cnt <= cnt + class_idx_t'(1);
                    end
                end
                ST_RESULT: begin
                    if (!out_valid) begin
                        class_idx <= idx_reg;
                        top_prob  <= best_reg;
                        margin    <= margin_calc;
                        confident <= (best_reg >= CONF_THRESH) && (margin_calc >= MARGIN_MIN);
                        out_valid <= 1'b1;
                    end else if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase

            // Placed after the case so a back-to-back capture overrides the return to IDLE.
            if (capture) begin
                best_reg   <= elem_in[0];
                second_reg <= '0;
                idx_reg    <= '0;
                cnt        <= class_idx_t'(1);
                state      <= ST_SCAN;
            end
        end
    end

    // Set has priority over clear when both happen in one cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            overrun <= 1'b0;
        end else if (drop) begin
            overrun <= 1'b1;
        end else if (clear_overrun) begin
            overrun <= 1'b0;
        end
    end

endmodule

// File: tb/tb_softmax_argmax_classifier.sv
// Self-checking bench for softmax_argmax_classifier: a transaction-level
// reference (argmax / second-max of the vector, 10-cycle result timeline,
// overrun rule) checked every cycle, plus hand-computed directed vectors.
module tb_softmax_argmax_classifier;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [159:0] prob_in = '0;
    logic         in_valid = 1'b0;
    logic         out_ready = 1'b0;
    logic         clear_overrun = 1'b0;
    logic         out_valid;
    logic [3:0]   class_idx;
    logic [15:0]  top_prob;
    logic [15:0]  margin;
    logic         confident;
    logic         busy;
    logic         overrun;

    int n_tests = 0;
    int n_fail  = 0;

    softmax_argmax_classifier dut (
        .clk           (clk),
        .rst           (rst),
        .prob_in       (prob_in),
        .in_valid      (in_valid),
        .out_ready     (out_ready),
        .clear_overrun (clear_overrun),
        .out_valid     (out_valid),
        .class_idx     (class_idx),
        .top_prob      (top_prob),
        .margin        (margin),
        .confident     (confident),
        .busy          (busy),
        .overrun       (overrun)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0]  idx;
        logic [15:0] top;
        logic [15:0] mrg;
        logic        conf;
    } res_t;

    // Reference: lowest-index maximum, second = largest of all other entries.
    function automatic res_t model_eval(input logic [159:0] v);
        res_t r;
        int   w;
        logic [15:0] sec;
        w = 0;
        for (int i = 1; i < 10; i++) begin
            if (v[i*16 +: 16] > v[w*16 +: 16]) w = i;
        end
        sec = 16'h0000;
        for (int i = 0; i < 10; i++) begin
            if (i != w && v[i*16 +: 16] > sec) sec = v[i*16 +: 16];
        end
        r.idx  = 4'(w);
        r.top  = v[w*16 +: 16];
        r.mrg  = r.top - sec;
        r.conf = (r.top >= 16'h4000) && (r.mrg >= 16'h0CCD);
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Transaction-level reference timeline.
    logic [31:0] cyc       = 0;
    logic [31:0] m_due     = 0;
    logic        m_valid   = 1'b0;
    logic        m_busy    = 1'b0;
    logic        m_overrun = 1'b0;
    res_t        m_pend    = '0;
    res_t        m_cur     = '0;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_valid   <= 1'b0;
            m_busy    <= 1'b0;
            m_overrun <= 1'b0;
            m_pend    <= '0;
            m_cur     <= '0;
        end else begin : step
            logic xfer;
            logic acc;
            xfer = m_valid && out_ready;
            acc  = in_valid && (!m_busy || xfer);
            cyc <= cyc + 1;
            if (in_valid && !acc)   m_overrun <= 1'b1;
            else if (clear_overrun) m_overrun <= 1'b0;
            if (acc) begin
                m_pend <= model_eval(prob_in);
                m_due  <= cyc + 10;
                m_busy <= 1'b1;
            end else if (xfer) begin
                m_busy <= 1'b0;
            end
            if (xfer) begin
                m_valid <= 1'b0;
            end else if (m_busy && !m_valid && cyc == m_due) begin
                m_valid <= 1'b1;
                m_cur   <= m_pend;
            end
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            chk("m_out_valid", 32'(out_valid), 32'(m_valid));
            chk("m_class_idx", 32'(class_idx), 32'(m_cur.idx));
            chk("m_top_prob",  32'(top_prob),  32'(m_cur.top));
            chk("m_margin",    32'(margin),    32'(m_cur.mrg));
            chk("m_confident", 32'(confident), 32'(m_cur.conf));
            chk("m_busy",      32'(busy),      32'(m_busy));
            chk("m_overrun",   32'(overrun),   32'(m_overrun));
        end
    end

    task automatic send(input logic [159:0] v);
        prob_in  = v;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_valid(output int lat);
        lat = -1;
        for (int k = 1; k <= 30; k++) begin
            @(posedge clk);
            #1;
            if (out_valid) begin
                lat = k;
                break;
            end
        end
        if (lat < 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL wait_valid: no out_valid within 30 cycles");
        end
    endtask

    task automatic run_vec(input string name, input logic [159:0] v, input logic [3:0] e_idx,
                           input logic [15:0] e_top, input logic [15:0] e_mrg, input logic e_conf);
        int lat;
        send(v);
        wait_valid(lat);
        chk({name, "_latency"}, 32'(lat), 32'd10);
        chk({name, "_idx"},  32'(class_idx), 32'(e_idx));
        chk({name, "_top"},  32'(top_prob),  32'(e_top));
        chk({name, "_mrg"},  32'(margin),    32'(e_mrg));
        chk({name, "_conf"}, 32'(confident), 32'(e_conf));
        $display("[TB] %s: idx=%0d top=%h margin=%h conf=%0d lat=%0d",
                 name, class_idx, top_prob, margin, confident, lat);
        @(posedge clk);
        #1;
        chk({name, "_drop_valid"}, 32'(out_valid), 32'd0);
        chk({name, "_keep_idx"},   32'(class_idx), 32'(e_idx));
    endtask

    initial begin
        logic [159:0] v;
        int lat;

        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("reset_valid",   32'(out_valid), 32'd0);
        chk("reset_busy",    32'(busy),      32'd0);
        chk("reset_overrun", 32'(overrun),   32'd0);
        chk("reset_idx",     32'(class_idx), 32'd0);

        out_ready = 1'b1;

        v = '0; v[3*16 +: 16] = 16'h7FFF;
        run_vec("onehot", v, 4'd3, 16'h7FFF, 16'h7FFF, 1'b1);

        v = {10{16'h0400}}; v[2*16 +: 16] = 16'h3000; v[7*16 +: 16] = 16'h3000;
        run_vec("tie", v, 4'd2, 16'h3000, 16'h0000, 1'b0);

        v = {10{16'h0CCC}};
        run_vec("uniform", v, 4'd0, 16'h0CCC, 16'h0000, 1'b0);

        v = '0; v[4*16 +: 16] = 16'h4000; v[0*16 +: 16] = 16'h3333;
        run_vec("thresh_edge", v, 4'd4, 16'h4000, 16'h0CCD, 1'b1);

        v = {10{16'h0010}}; v[0*16 +: 16] = 16'h7000; v[6*16 +: 16] = 16'h6F00; v[9*16 +: 16] = 16'h6F00;
        run_vec("lead_first", v, 4'd0, 16'h7000, 16'h0100, 1'b0);

        // Backpressure hold with a dropped vector.
        out_ready = 1'b0;
        v = {10{16'h0100}}; v[5*16 +: 16] = 16'h6000; v[1*16 +: 16] = 16'h2000;
        send(v);
        wait_valid(lat);
        chk("hold_latency", 32'(lat), 32'd10);
        $display("[TB] hold: idx=%0d top=%h margin=%h conf=%0d", class_idx, top_prob, margin, confident);
        repeat (8) begin
            @(posedge clk);
            #1;
            chk("hold_valid", 32'(out_valid), 32'd1);
            chk("hold_top",   32'(top_prob),  32'h6000);
        end
        v = '0; v[0*16 +: 16] = 16'h7FFF;
        send(v);
        chk("overrun_set", 32'(overrun),   32'd1);
        chk("drop_idx",    32'(class_idx), 32'd5);
        repeat (10) begin
            @(posedge clk);
            #1;
            chk("hold_valid2", 32'(out_valid), 32'd1);
            chk("hold_mrg",    32'(margin),    32'h4000);
            chk("hold_conf",   32'(confident), 32'd1);
        end
        clear_overrun = 1'b1;
        @(posedge clk);
        #1;
        clear_overrun = 1'b0;
        chk("overrun_clear", 32'(overrun), 32'd0);

        // Back-to-back: new vector in the transfer cycle.
        out_ready = 1'b1;
        v = '0; v[9*16 +: 16] = 16'h5000; v[8*16 +: 16] = 16'h4F00;
        send(v);
        chk("b2b_valid_low", 32'(out_valid), 32'd0);
        chk("b2b_busy",      32'(busy),      32'd1);
        wait_valid(lat);
        chk("b2b_latency", 32'(lat),       32'd10);
        chk("b2b_idx",     32'(class_idx), 32'd9);
        chk("b2b_mrg",     32'(margin),    32'h0100);
        chk("b2b_conf",    32'(confident), 32'd0);
        chk("b2b_overrun", 32'(overrun),   32'd0);
        $display("[TB] b2b: idx=%0d top=%h margin=%h conf=%0d lat=%0d",
                 class_idx, top_prob, margin, confident, lat);
        @(posedge clk);
        #1;

        // Reset in the middle of a scan.
        v = '0; v[1*16 +: 16] = 16'h7000;
        send(v);
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_busy",  32'(busy),      32'd0);
        chk("rst_idx",   32'(class_idx), 32'd0);
        chk("rst_top",   32'(top_prob),  32'd0);
        chk("rst_mrg",   32'(margin),    32'd0);
        chk("rst_conf",  32'(confident), 32'd0);
        $display("[TB] reset mid-scan applied");
        @(posedge clk);
        #1;
        rst = 1'b1;
        repeat (15) begin
            @(posedge clk);
            #1;
            chk("post_rst_quiet", 32'(out_valid), 32'd0);
        end

        v = '0; v[8*16 +: 16] = 16'h7FFF; v[7*16 +: 16] = 16'h1000;
        run_vec("recover", v, 4'd8, 16'h7FFF, 16'h6FFF, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
